vermi_input_port: RTL and testbench
===================================

// Module: vermi_input_port
// PURPOSE
//  Bus responder that lets the CPU read data from outside the design.
//  A host/testbench byte stream (valid/ready) fills a synchronous FIFO.
//  The CPU drains the FIFO through memory-mapped registers on a Vermibus.
//  Sits beside the text-output and tick devices in the device decode of a system top.
// PARAMETERS
//  DEPTH     16  FIFO entries; power of two, >= 2
//  IN_WIDTH  8   stream data width, 1..32; zero-extended to 32 bits on rdata
// PORTS
//  clk       input   1         system clock, all logic on posedge
//  reset     input   1         synchronous, active-high
//  bus       modport Vermibus.read_write_response  CPU-side register port
//  in_valid  input   1         host stream: data word offered
//  in_data   input   IN_WIDTH  host stream: data word
//  in_ready  output  1         host stream: FIFO can accept (= !full, from registered state)
//  irq       output  1         data-available interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FIFO empty, count=0, irq_enable=0, irq=0, in_ready=1.
//  Register map, decoded on bus.address[3:2]; address[31:4] ignored (top decodes):
//   0x0 DATA    R: FIFO head zero-extended; pops the head. Read when empty returns 0, no pop. W: ignored.
//   0x4 STATUS  R: [0]=not_empty [1]=full [15:8]=count; other bits 0. W: ignored.
//   0x8 CONTROL W: [0]=flush (1 empties FIFO) [1]=irq_enable. R: {30'b0, irq_enable, 1'b0}.
//   0xC         R: 0. W: ignored.
//  Handshake: bus.ready = bus.valid, same cycle (zero wait states); rdata is combinational from state.
//   Write = valid && wstrobe != 0; read = valid && wstrobe == 0.
//   Side effects (pop, flush, enable) take effect at the posedge of the accepting cycle.
//  Push: in_valid && in_ready at posedge.
//   Push and pop in the same cycle: count unchanged.
//   Push into an empty FIFO with a simultaneous DATA read: read returns 0, push lands.
//  Full: in_ready=0; in_data is not sampled and nothing is dropped.
//  Flush with a simultaneous push: flush wins, count=0, pushed word discarded.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
//  STATUS.count is zero-extended into [15:8]; DEPTH <= 255 is required.
//  Reset mid-stream: same as power-up reset, contents lost, in_ready=1 the next cycle.
// CONFIGURATION
//  Macro VERMI_INPUT_IRQ_EN:
//   defined: irq registered = irq_enable && not_empty (updates one cycle after the causing edge);
//            CONTROL[1] is writable.
//   undefined: irq tied to 0; CONTROL[1] is write-ignored and reads 0; no irq_enable flop.
// STRUCTURE
//  Package vermi_input_pkg:
//   register offset localparams DATA/STATUS/CONTROL;
//   STATUS/CONTROL bit-position localparams;
//   typedef control_t {irq_enable, flush}.
//  Sub-module vermi_sync_fifo #(WIDTH, DEPTH):
//   ports push, push_data, pop, flush, head, count, empty, full;
//   flush dominates push and pop.
//  Top level: register decode, rdata mux, control flop, irq flop.
// TESTING
//  1 Reset, then read STATUS -> 0x0000_0000; in_ready=1; irq=0.
//  2 Push 0x41,0x42,0x43; read STATUS -> 0x0000_0301; read DATA x3 -> 0x41,0x42,0x43; STATUS -> 0.
//  3 Push 16 words with DEPTH=16 -> in_ready=0, STATUS=0x0000_1003; hold in_valid 5 cycles;
//    read DATA -> first word; in_ready=1 next cycle; no word lost.
//  4 Empty FIFO, DATA read and push 0x55 in the same cycle -> read returns 0; then DATA -> 0x55.
//  5 Push 4 words; write CONTROL=0x1 with a simultaneous push -> STATUS=0; DATA read -> 0.
//  6 With VERMI_INPUT_IRQ_EN: write CONTROL=0x2; push 0x7 -> irq=1 one cycle later;
//    DATA read -> irq=0 next cycle. Without the macro: irq stays 0; CONTROL reads 0.

Source files
------------

// File: rtl/vermi_input_pkg.sv
// Shared register map, bit positions and control-word layout for the
// Vermibus input-port device.
package vermi_input_pkg;

  // Register byte offsets within the device window.
  localparam logic [3:0] DATA_OFS    = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] CONTROL_OFS = 4'h8;

  localparam int STATUS_NOT_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT      = 1;
  localparam int STATUS_COUNT_LSB     = 8;
  localparam int STATUS_COUNT_W       = 8;

  localparam int CONTROL_FLUSH_BIT  = 0;
  localparam int CONTROL_IRQ_EN_BIT = 1;

  typedef struct packed {
    logic irq_enable;
    logic flush;
  } control_t;

  // Word index of a register, as decoded from address[3:2].
  function automatic logic [1:0] reg_index(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

// File: rtl/vermi_input_port_if.sv
// Vermibus: single-beat CPU register bus. The requester drives address/strobe/data,
// the responder returns ready and read data.
interface Vermibus;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport read_write_request (
    output valid, address, wstrobe, wdata,
    input  ready, rdata
  );

  modport read_write_response (
    input  valid, address, wstrobe, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/vermi_sync_fifo.sv
// Synchronous FIFO with occupancy count; flush dominates push and pop.
module vermi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only: never reset, only written on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vermi_input_port.sv
// Vermibus input device: host byte stream -> FIFO -> CPU-readable DATA/STATUS/CONTROL.
// Optional data-available interrupt enabled by defining VERMI_INPUT_IRQ_EN.
module vermi_input_port #(
  parameter int DEPTH    = 16,
  parameter int IN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  Vermibus.read_write_response bus,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 irq
);
  import vermi_input_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] DATA_IDX    = reg_index(DATA_OFS);
  localparam logic [1:0] STATUS_IDX  = reg_index(STATUS_OFS);
  localparam logic [1:0] CONTROL_IDX = reg_index(CONTROL_OFS);

  if ((DEPTH < 2) || (DEPTH > 255) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("vermi_input_port: DEPTH must be a power of two in 2..128");
  end
  if ((IN_WIDTH < 1) || (IN_WIDTH > 32)) begin : g_bad_width
    $error("vermi_input_port: IN_WIDTH must be 1..32");
  end

  logic                bus_rd, bus_wr;
  logic [1:0]          reg_sel;
  logic                ctrl_sel;
  control_t            ctrl_wr;
  logic                fifo_pop, fifo_flush;
  logic [IN_WIDTH-1:0] fifo_head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty, fifo_full;
  logic                irq_enable;

  assign bus.ready  = bus.valid;
  assign bus_rd     = bus.valid && (bus.wstrobe == 4'b0000);
  assign bus_wr     = bus.valid && (bus.wstrobe != 4'b0000);
  assign reg_sel    = bus.address[3:2];
  assign ctrl_sel   = bus_wr && (reg_sel == CONTROL_IDX);
  assign ctrl_wr    = control_t'({bus.wdata[CONTROL_IRQ_EN_BIT], bus.wdata[CONTROL_FLUSH_BIT]});
  assign fifo_pop   = bus_rd && (reg_sel == DATA_IDX);
  assign fifo_flush = ctrl_sel && ctrl_wr.flush;
  assign in_ready   = !fifo_full;

  vermi_sync_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef VERMI_INPUT_IRQ_EN
  logic irq_enable_q, irq_enable_d;
  logic irq_q, irq_d;

  // irq follows registered state, so it lags the causing edge by one cycle.
  always_comb begin
    irq_enable_d = irq_enable_q;
    if (ctrl_sel) irq_enable_d = ctrl_wr.irq_enable;
    irq_d = irq_enable_q && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      irq_enable_q <= irq_enable_d;
      irq_q        <= irq_d;
    end
  end

  assign irq_enable = irq_enable_q;
  assign irq        = irq_q;
`else
  logic unused_irq_enable_bit;
  assign unused_irq_enable_bit = ctrl_wr.irq_enable;
  assign irq_enable = 1'b0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    bus.rdata = '0;
    case (reg_sel)
      DATA_IDX: begin
        if (!fifo_empty) bus.rdata = 32'(fifo_head);
      end
      STATUS_IDX: begin
        bus.rdata[STATUS_NOT_EMPTY_BIT] = !fifo_empty;
        bus.rdata[STATUS_FULL_BIT]      = fifo_full;
        bus.rdata[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
      end
      CONTROL_IDX: begin
        bus.rdata[CONTROL_IRQ_EN_BIT] = irq_enable;
      end
      default: bus.rdata = '0;
    endcase
  end

  // Upper address bits are decoded by the system top; byte lanes are ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.address[31:4], bus.address[1:0], bus.wdata[31:2]};

endmodule

// File: tb/tb_vermi_input_port.sv
// Self-checking bench for vermi_input_port: vector table plus scoreboarded corner sequences.
module tb_vermi_input_port;
  localparam int DEPTH    = 16;
  localparam int IN_WIDTH = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic [IN_WIDTH-1:0] in_data = '0;
  logic                in_ready;
  logic                irq;

  Vermibus bus_if ();

  vermi_input_port #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  model[$];
  logic [31:0] exp_q[$];

  typedef enum int {OP_PUSH, OP_RD, OP_WR} op_e;
  typedef struct {
    op_e         op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One bus cycle with optional simultaneous stream push; model follows the spec.
  task automatic cycle(input bit b_en, input logic [3:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input bit p_en, input logic [7:0] pd,
                       output logic [31:0] rd);
    bit is_dread, is_flush, acc;
    logic [31:0] e;
    bus_if.valid   = b_en;
    bus_if.address = {28'h0, addr};
    bus_if.wstrobe = strb;
    bus_if.wdata   = wd;
    in_valid       = p_en;
    in_data        = pd;
    is_dread = b_en && (strb == 4'h0) && (addr[3:2] == 2'd0);
    is_flush = b_en && (strb != 4'h0) && (addr[3:2] == 2'd2) && wd[0];
    if (is_dread) exp_q.push_back((model.size() != 0) ? {24'h0, model[0]} : 32'h0);
    @(negedge clk);
    rd = bus_if.rdata;
    if (b_en) check("bus_ready", {31'h0, bus_if.ready}, 32'h1);
    acc = p_en && in_ready;
    if (p_en) check("in_ready", {31'h0, in_ready}, {31'h0, model.size() < DEPTH});
    if (is_dread) begin
      e = exp_q.pop_front();
      check("data_sb", rd, e);
      if (model.size() != 0) void'(model.pop_front());
    end
    if (is_flush) model.delete();
    else if (acc) model.push_back(pd);
    @(posedge clk); #1;
    bus_if.valid   = 1'b0;
    bus_if.wstrobe = 4'h0;
    in_valid       = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] addr, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    cycle(1'b1, addr, 4'h0, 32'h0, 1'b0, 8'h0, rd);
    check(nm, rd, exp);
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    cycle(1'b1, addr, 4'hF, wd, 1'b0, 8'h0, rd);
  endtask

  task automatic push_one(input logic [7:0] d);
    logic [31:0] rd;
    cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, d, rd);
  endtask

  vec_t vec[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  first;
    bus_if.valid = 1'b0; bus_if.address = '0; bus_if.wstrobe = '0; bus_if.wdata = '0;

    vec[0]  = '{OP_PUSH, 4'h0, 32'h41,      32'h0,     "push41"};
    vec[1]  = '{OP_PUSH, 4'h0, 32'h42,      32'h0,     "push42"};
    vec[2]  = '{OP_PUSH, 4'h0, 32'h43,      32'h0,     "push43"};
    vec[3]  = '{OP_RD,   4'h4, 32'h0,       32'h0301,  "status_3"};
    vec[4]  = '{OP_RD,   4'h0, 32'h0,       32'h41,    "data_41"};
    vec[5]  = '{OP_RD,   4'h0, 32'h0,       32'h42,    "data_42"};
    vec[6]  = '{OP_RD,   4'h0, 32'h0,       32'h43,    "data_43"};
    vec[7]  = '{OP_RD,   4'h4, 32'h0,       32'h0,     "status_empty"};
    vec[8]  = '{OP_RD,   4'h0, 32'h0,       32'h0,     "data_empty"};
    vec[9]  = '{OP_RD,   4'hC, 32'h0,       32'h0,     "reserved_rd"};
    vec[10] = '{OP_PUSH, 4'h0, 32'h10,      32'h0,     "push10"};
    vec[11] = '{OP_WR,   4'h0, 32'hFFFFFFFF, 32'h0,    "wr_data_ign"};
    vec[12] = '{OP_WR,   4'h4, 32'hFFFFFFFF, 32'h0,    "wr_status_ign"};
    vec[13] = '{OP_RD,   4'h4, 32'h0,       32'h0101,  "status_1"};
    vec[14] = '{OP_RD,   4'h8, 32'h0,       32'h0,     "control_rd"};
    vec[15] = '{OP_RD,   4'h0, 32'h0,       32'h10,    "data_10"};
    vec[16] = '{OP_RD,   4'h4, 32'h0,       32'h0,     "status_empty2"};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    rd_reg(4'h4, 32'h0, "reset_status");

    // Table-driven basic traffic
    for (int i = 0; i < 17; i++) begin
      case (vec[i].op)
        OP_PUSH: cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, vec[i].data[7:0], rd);
        OP_WR:   cycle(1'b1, vec[i].addr, 4'hF, vec[i].data, 1'b0, 8'h0, rd);
        default: begin
          cycle(1'b1, vec[i].addr, 4'h0, 32'h0, 1'b0, 8'h0, rd);
          check(vec[i].name, rd, vec[i].exp);
        end
      endcase
    end

    // Fill to full (pointers wrap), back-pressure, then drain
    for (int i = 0; i < DEPTH; i++) push_one(8'($urandom_range(0, 255)));
    first = model[0];
    @(negedge clk);
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    rd_reg(4'h4, 32'h1003, "status_full");
    for (int i = 0; i < 5; i++) push_one(8'hEE);
    cycle(1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 8'hEE, rd);
    check("full_first_word", rd, {24'h0, first});
    @(negedge clk);
    check("ready_after_pop", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    push_one(8'hEE);
    rd_reg(4'h4, 32'h1003, "status_refull");
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 8'h0, rd);
    rd_reg(4'h0, 32'hEE, "last_word");
    rd_reg(4'h4, 32'h0, "status_drained");

    // Read DATA on empty with simultaneous push
    cycle(1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 8'h55, rd);
    check("empty_rd_push", rd, 32'h0);
    rd_reg(4'h0, 32'h55, "data_55");

    // Flush with simultaneous push
    for (int i = 0; i < 4; i++) push_one(8'(8'h20 + i));
    cycle(1'b1, 4'h8, 4'hF, 32'h1, 1'b1, 8'h99, rd);
    rd_reg(4'h4, 32'h0, "status_flushed");
    rd_reg(4'h0, 32'h0, "data_flushed");

    // Interrupt
    wr_reg(4'h8, 32'h2);
`ifdef VERMI_INPUT_IRQ_EN
    rd_reg(4'h8, 32'h2, "control_irq_en");
    push_one(8'h07);
    @(negedge clk);
    check("irq_lag", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_set", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    rd_reg(4'h0, 32'h07, "data_07");
    @(negedge clk);
    check("irq_hold", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("irq_clear", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    wr_reg(4'h8, 32'h0);
`else
    rd_reg(4'h8, 32'h0, "control_irq_off");
    push_one(8'h07);
    @(negedge clk);
    @(negedge clk);
    check("irq_off", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    rd_reg(4'h0, 32'h07, "data_07");
`endif

    // Reset mid-stream
    for (int i = 0; i < 3; i++) push_one(8'(8'h60 + i));
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    model.delete();
    @(negedge clk);
    check("midreset_in_ready", {31'h0, in_ready}, 32'h1);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    rd_reg(4'h4, 32'h0, "midreset_status");
    rd_reg(4'h0, 32'h0, "midreset_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
